// File: rtl/qdma_master.sv
// qdma_master: wishbone master for DELQA DMA word transfers, with CPU-yield arbitration
// and non-existent-memory detection by ack timeout.
module qdma_master #(
  parameter int TOUT_CYCLES = 64,
  parameter int HOLD_MAX    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        dma_req_i,
  output logic        dma_gnt_o,
  input  logic [21:0] dma_adr_i,
  input  logic [15:0] dma_dat_i,
  output logic [15:0] dma_dat_o,
  input  logic        dma_stb_i,
  input  logic        dma_we_i,
  output logic        dma_ack_o,
  output logic        dma_err_o,
  output logic [21:0] wbm_adr_o,
  output logic [15:0] wbm_dat_o,
  input  logic [15:0] wbm_dat_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [1:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic        cpu_req_i,
  input  logic        cpu_cyc_i,
  output logic        nxm_o,
  input  logic        nxm_clr_i
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_CYCLE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [7:0] TOUT_LAST = 8'(TOUT_CYCLES - 1);
  localparam logic [8:0] HOLD      = 9'(HOLD_MAX);
  logic [2:0]  state_q, state_d;
  logic        gnt_q, gnt_d, cyc_q, cyc_d, we_q, we_d, ack_q, ack_d, err_q, err_d, nxm_q, nxm_d;
  logic        nxm_set;
  logic [21:0] adr_q, adr_d;
  logic [15:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic [7:0]  cnt_q, cnt_d, tmr_q, tmr_d, cnt_inc;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    ack_d   = ack_q;
    err_d   = err_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    nxm_set = 1'b0;
    cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
    case (state_q)
      // GAP behaves like IDLE except it always costs one clock without grant
      S_IDLE, S_GAP: begin
        cnt_d   = 8'd0;
        gnt_d   = dma_req_i & ~cpu_cyc_i;
        state_d = (dma_req_i & ~cpu_cyc_i) ? S_GRANT : S_IDLE;
      end
      S_GRANT:
        if (!dma_req_i) begin
          state_d = S_GAP;
          gnt_d   = 1'b0;
        end else if (dma_stb_i) begin
          state_d = S_CYCLE;
          cyc_d   = 1'b1;
          adr_d   = dma_adr_i & ~22'd1;
          wdat_d  = dma_dat_i;
          we_d    = dma_we_i;
          tmr_d   = 8'd0;
        end
      S_CYCLE:
        if (wbm_ack_i) begin
          state_d = S_DONE;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b0;
          rdat_d  = we_q ? rdat_q : wbm_dat_i;
        end else if (tmr_q == TOUT_LAST) begin
          state_d = S_DONE;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdat_d  = 16'd0;
          nxm_set = 1'b1;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      S_DONE:
        if (!dma_stb_i) begin
          ack_d = 1'b0;
          err_d = 1'b0;
          cnt_d = cnt_inc;
          if (!dma_req_i || (cpu_req_i && {1'b0, cnt_inc} >= HOLD)) begin
            state_d = S_GAP;
            gnt_d   = 1'b0;
          end else begin
            state_d = S_GRANT;
          end
        end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 1'b0;
        cyc_d   = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
    nxm_d = nxm_set | (nxm_q & ~nxm_clr_i);
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      nxm_q   <= 1'b0;
      adr_q   <= 22'd0;
      wdat_q  <= 16'd0;
      rdat_q  <= 16'd0;
      cnt_q   <= 8'd0;
      tmr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      nxm_q   <= nxm_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end
  assign dma_gnt_o = gnt_q;
  assign dma_dat_o = rdat_q;
  assign dma_ack_o = ack_q;
  assign dma_err_o = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = {2{cyc_q}};
  assign nxm_o     = nxm_q;
endmodule
